// File: rtl/div_monitor_pkg.sv
// rtl/div_monitor_pkg.sv - FSM encoding and default sizing shared by div_monitor
package div_monitor_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEAS_A, MEAS_B} state_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_EXP_PAIR = 11;
  localparam int DEF_LOCK_CNT = 4;

endpackage

// File: rtl/div_monitor_sync_edge.sv
// rtl/div_monitor_sync_edge.sv - two-flop synchronizer with registered rise/fall detect
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // s3 is the history flop; edges are judged on the already-synchronized s2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/div_monitor.sv
// rtl/div_monitor.sv - measures period/high time of a half-integer divided clock and tracks ratio lock
module div_monitor
  import div_monitor_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int EXP_PAIR = DEF_EXP_PAIR,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic [CNT_W:0]   pair_out,
  output logic             meas_valid,
  output logic             lock,
  output logic             err_ratio,
  output logic             err_timeout
);

  localparam int PAIR_W  = CNT_W + 1;
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [PAIR_W-1:0]  PAIR_EXP   = PAIR_W'(EXP_PAIR);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_CNT);

  state_t             state;
  logic               rise, fall, in_high, measuring;
  logic [CNT_W-1:0]   period_cnt, high_cnt, stored;
  logic [MATCH_W-1:0] match_cnt;
  logic [PAIR_W-1:0]  pair_sum;

  sync_edge u_sync (
    .clk  (clk_in),
    .rst  (rst),
    .din  (div_in),
    .rise (rise),
    .fall (fall)
  );

  assign measuring = (state == MEAS_A) || (state == MEAS_B);
  assign pair_sum  = {1'b0, stored} + {1'b0, period_cnt};

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      period_cnt  <= '0;
      high_cnt    <= '0;
      stored      <= '0;
      match_cnt   <= '0;
      in_high     <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
      pair_out    <= '0;
      meas_valid  <= 1'b0;
      lock        <= 1'b0;
      err_ratio   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (err_clr) begin
        err_ratio   <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (!enable) begin
        state      <= IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
        stored     <= '0;
        match_cnt  <= '0;
        in_high    <= 1'b0;
        lock       <= 1'b0;
      end else begin
        lock <= (match_cnt == MATCH_FULL);
        if (rise) begin
          period_cnt <= CNT_ONE;
          high_cnt   <= CNT_ONE;
          in_high    <= 1'b1;
        end else begin
          if (measuring && period_cnt != CNT_MAX) period_cnt <= period_cnt + CNT_ONE;
          if (fall) in_high <= 1'b0;
          else if (in_high && high_cnt != CNT_MAX) high_cnt <= high_cnt + CNT_ONE;
        end
        // later assignments below override the generic counter/lock updates above
        case (state)
          IDLE: state <= ARM;
          ARM:  if (rise) state <= MEAS_A;
          MEAS_A, MEAS_B: begin
            if (rise) begin
              period_out <= period_cnt;
              high_out   <= high_cnt;
              meas_valid <= 1'b1;
              if (state == MEAS_A) begin
                stored <= period_cnt;
                state  <= MEAS_B;
              end else begin
                pair_out <= pair_sum;
                state    <= MEAS_A;
                if (pair_sum == PAIR_EXP) begin
                  if (match_cnt != MATCH_FULL) match_cnt <= match_cnt + MATCH_W'(1);
                end else begin
                  match_cnt <= '0;
                  lock      <= 1'b0;
                  err_ratio <= 1'b1;
                end
              end
            end else if (period_cnt == CNT_MAX) begin
              err_timeout <= 1'b1;
              lock        <= 1'b0;
              match_cnt   <= '0;
              period_cnt  <= '0;
              state       <= ARM;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_monitor.sv
// tb/tb_div_monitor.sv - scoreboard bench for div_monitor with directed divided-clock trains
module tb_div_monitor;
  import div_monitor_pkg::*;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst, enable, div_in, err_clr;
  logic [CNT_W-1:0] period_out, high_out;
  logic [CNT_W:0]   pair_out;
  logic             meas_valid, lock, err_ratio, err_timeout;

  div_monitor #(.CNT_W(CNT_W), .EXP_PAIR(11), .LOCK_CNT(4)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .enable      (enable),
    .div_in      (div_in),
    .err_clr     (err_clr),
    .period_out  (period_out),
    .high_out    (high_out),
    .pair_out    (pair_out),
    .meas_valid  (meas_valid),
    .lock        (lock),
    .err_ratio   (err_ratio),
    .err_timeout (err_timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int p;
    int h;
    bit pc;
    int pair;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0, lrise = 0, mv_cnt = 0, mv_base = 0;
  int   lp = 0, lh = 0;
  bit   have_prev = 1'b0, bphase = 1'b0, prev_mv = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (rst) begin
      prev_mv = 1'b0;
    end else begin
      if (meas_valid) begin
        mv_cnt++;
        chk("mv_single_cycle", int'(prev_mv), 0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_meas_valid: got period %0d with empty scoreboard", period_out);
        end else begin
          e = q.pop_front();
          chk("period_out", int'(period_out), e.p);
          chk("high_out", int'(high_out), e.h);
          if (e.pc) chk("pair_out", int'(pair_out), e.pair);
        end
      end
      prev_mv = meas_valid;
    end
  end

  task automatic restart_seq();
    have_prev = 1'b0;
    bphase    = 1'b0;
  endtask

  // one div_in period starting with a rise; the rise closes the previous period
  task automatic rise_period(input int p, input int h, input int pair_exp);
    if (have_prev) begin
      q.push_back('{p: lp, h: lh, pc: bphase, pair: pair_exp});
      bphase = ~bphase;
    end
    have_prev = 1'b1;
    lp        = p;
    lh        = h;
    lrise     = cyc;
    div_in    = 1'b1;
    repeat (h) @(negedge clk_in);
    div_in = 1'b0;
    repeat (p - h) @(negedge clk_in);
  endtask

  task automatic train65(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      if (k % 2 == 0) rise_period(6, 3, 11);
      else            rise_period(5, 2, 11);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period_out"}, int'(period_out), 0);
    chk({tag, "_high_out"}, int'(high_out), 0);
    chk({tag, "_pair_out"}, int'(pair_out), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_lock"}, int'(lock), 0);
    chk({tag, "_err_ratio"}, int'(err_ratio), 0);
    chk({tag, "_err_timeout"}, int'(err_timeout), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; div_in = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk_in);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk_in);

    // 6/5 alternating train: lock only after the fourth matching pair
    enable = 1'b1;
    restart_seq();
    @(negedge clk_in);
    train65(0, 7);
    chk("lock_after_3_pairs", int'(lock), 0);
    train65(8, 10);
    chk("lock_after_4_pairs", int'(lock), 1);
    chk("err_ratio_clean", int'(err_ratio), 0);
    chk("err_timeout_clean", int'(err_timeout), 0);

    // hold div_in low: timeout 255 counts after the last measured rise
    while (cyc < lrise + 250) @(negedge clk_in);
    chk("timeout_not_early", int'(err_timeout), 0);
    chk("lock_before_timeout", int'(lock), 1);
    while (cyc < lrise + 265) @(negedge clk_in);
    chk("timeout_set", int'(err_timeout), 1);
    chk("lock_after_timeout", int'(lock), 0);
    chk("state_arm_after_timeout", int'(dut.state), int'(ARM));
    err_clr = 1'b1;
    @(negedge clk_in);
    err_clr = 1'b0;
    chk("timeout_cleared", int'(err_timeout), 0);
    repeat (5) @(negedge clk_in);
    chk("timeout_stays_clear", int'(err_timeout), 0);

    // 6/6 train: every pair is 12 -> ratio error, never lock
    restart_seq();
    rise_period(6, 3, 12);
    rise_period(6, 3, 12);
    chk("no_ratio_err_before_pair", int'(err_ratio), 0);
    fork
      rise_period(6, 3, 12);
      begin
        repeat (5) @(negedge clk_in);
        chk("ratio_err_first_pair", int'(err_ratio), 1);
        chk("lock_with_bad_ratio", int'(lock), 0);
        err_clr = 1'b1;
      end
    join
    err_clr = 1'b0;
    chk("ratio_err_cleared", int'(err_ratio), 0);
    rise_period(6, 3, 12);
    chk("ratio_err_stays_clear", int'(err_ratio), 0);
    fork
      rise_period(6, 3, 12);
      begin
        repeat (3) @(negedge clk_in);
        err_clr = 1'b1;
        @(negedge clk_in);
        err_clr = 1'b0;
        chk("ratio_err_set_beats_clear", int'(err_ratio), 1);
      end
    join
    chk("lock_never_6_6", int'(lock), 0);

    // enable drop while locked, then relock from scratch
    enable = 1'b0;
    repeat (3) @(negedge clk_in);
    enable = 1'b1;
    restart_seq();
    train65(0, 8);
    chk("lock_before_disable", int'(lock), 1);
    enable = 1'b0;
    @(negedge clk_in);
    chk("lock_drop_on_disable", int'(lock), 0);
    repeat (4) @(negedge clk_in);
    chk("period_held_disabled", int'(period_out), 5);
    chk("high_held_disabled", int'(high_out), 2);
    chk("state_idle_disabled", int'(dut.state), int'(IDLE));
    enable = 1'b1;
    restart_seq();
    train65(0, 7);
    chk("no_relock_3_pairs", int'(lock), 0);
    train65(8, 8);
    chk("relock_4_pairs", int'(lock), 1);

    // 50% square wave period 8; ends in MEAS_B
    enable = 1'b0;
    @(negedge clk_in);
    enable = 1'b1;
    restart_seq();
    mv_base = mv_cnt;
    repeat (6) rise_period(8, 4, 16);
    chk("mv_count_square", mv_cnt - mv_base, 5);
    chk("state_meas_b", int'(dut.state), int'(MEAS_B));

    // async reset mid-measurement
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    restart_seq();
    mv_base = mv_cnt;
    rise_period(8, 4, 16);
    chk("no_mv_after_first_rise", mv_cnt - mv_base, 0);
    rise_period(8, 4, 16);
    chk("mv_after_second_rise", mv_cnt - mv_base, 1);

    repeat (10) @(negedge clk_in);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_monitor.md
DIV_MONITOR -- requirements
Module: div_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of period/high-time counters.
REQ-002 SHALL have parameter EXP_PAIR, default 11, expected clk_in cycles across two consecutive div_in periods (2N+1 for an N+0.5 divider).
REQ-003 SHALL have parameter LOCK_CNT, default 4, consecutive matching pairs required for lock.
REQ-004 SHALL have ports: clk_in input 1 system clock; rst input 1 asynchronous active-high reset.
REQ-005 SHALL have ports: enable input 1 measurement enable; div_in input 1 divided clock under test, asynchronous to clk_in; err_clr input 1 clears sticky errors.
REQ-006 SHALL have ports: period_out output CNT_W last period in clk_in cycles; high_out output CNT_W last high time in clk_in cycles; pair_out output CNT_W+1 sum of last two periods.
REQ-007 SHALL have ports: meas_valid output 1 one-cycle pulse on new period_out; lock output 1 ratio locked; err_ratio output 1 sticky mismatch; err_timeout output 1 sticky no-edge.

Function
REQ-008 SHALL pass div_in through a 2-flop synchronizer plus one history flop; rising/falling edge detect is registered from these.
REQ-009 SHALL use FSM states IDLE, ARM, MEAS_A, MEAS_B.
REQ-010 IDLE -> ARM when enable=1; any state -> IDLE when enable=0, clearing lock and counters, holding measurement outputs.
REQ-011 ARM -> MEAS_A on first detected rising edge; no meas_valid from ARM.
REQ-012 Period counter SHALL load 1 on a detected rise and increment each cycle; captured value equals clk_in cycles between consecutive rises (6-cycle spacing -> 6).
REQ-013 High counter SHALL count cycles with synchronized div_in=1 since last rise; captured into high_out at next rise.
REQ-014 On each rise in MEAS_A/MEAS_B: period_out, high_out update and meas_valid pulses the following cycle; latency from div_in rising at pins to meas_valid = 4 clk_in cycles.
REQ-015 MEAS_A -> MEAS_B on rise storing period; MEAS_B -> MEAS_A on rise, forming pair_out = stored + current (CNT_W+1 bits, no overflow).
REQ-016 Pair compare on each MEAS_B->MEAS_A: match increments match counter (saturating at LOCK_CNT); mismatch clears it, deasserts lock, sets err_ratio.
REQ-017 lock SHALL assert the cycle after match counter reaches LOCK_CNT.
REQ-018 Period counter reaching all-ones without a rise SHALL set err_timeout, clear lock, return to ARM; counter saturates, never wraps.
REQ-019 err_clr SHALL clear both sticky errors next cycle; simultaneous new error and err_clr -> error remains set.
REQ-020 Falling edge with no intervening rise (div_in held high) SHALL not alter high_out; high counter saturates at all-ones.

Reset
REQ-021 On rst=1 all state asynchronously clears: FSM IDLE, synchronizer 0, counters 0, period_out/high_out/pair_out 0, meas_valid/lock/err_ratio/err_timeout 0.
REQ-022 rst asserted mid-measurement SHALL discard partial counts; first post-reset meas_valid requires ARM and two rises.

Structure
REQ-023 A shared package SHALL hold the FSM state enum and default CNT_W/EXP_PAIR/LOCK_CNT constants.
REQ-024 The 2-flop synchronizer with edge detect SHALL be a sub-module named sync_edge.

Verification
REQ-025 div_in alternating 6/5-cycle periods (N=5 model), enable=1 -> period_out alternates 6,5; pair_out=11; lock=1 after 4th pair; errors 0.
REQ-026 div_in periods 6/6 -> pair_out=12, err_ratio=1 at first pair, lock stays 0; err_clr pulse -> err_ratio=0 next cycle, reasserts at next pair.
REQ-027 div_in held low after lock, CNT_W=8 -> err_timeout=1 after 255 cycles from last rise, lock=0, FSM ARM.
REQ-028 rst pulsed mid-MEAS_B -> all outputs 0 immediately; after release, meas_valid not before second rise.
REQ-029 enable dropped while locked -> lock=0 next cycle, period_out held; re-enable -> ARM, fresh lock after 4 matching pairs.
REQ-030 div_in 50% square wave, period 8 -> period_out=8, high_out=4, meas_valid exactly one cycle per rise.
